// File: rtl/gate_pkg.sv
// Shared types and helpers for the gate_stretch trigger-to-gate converter.
package gate_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        GAP  = 2'd2
    } gate_state_t;

    // A zero-length request still produces a one-cycle gate.
    function automatic logic [31:0] gate_load_val(input logic [31:0] len);
        return (len == 32'd0) ? 32'd0 : len - 32'd1;
    endfunction

endpackage

// File: rtl/gate_down_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module gate_down_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_stretch.sv
// Stretches single-cycle triggers into gates of programmable length followed by a forced low gap.
// Define GATE_STRETCH_RETRIG_EN to let a trigger during a gate restart its length.
module gate_stretch
    import gate_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic [CNT_W-1:0] gate_len,
    output logic             gate,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    gate_state_t      state_q, state_d;
    logic             gate_q, gate_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] len_load;
    logic             retrig;

`ifdef GATE_STRETCH_RETRIG_EN
    assign retrig = trig;
`else
    assign retrig = 1'b0;
`endif

    assign len_load = CNT_W'(gate_load_val(32'(gate_len)));

    // One counter serves both the gate length and the gap length.
    gate_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d      = GATE;
                    cnt_load     = 1'b1;
                    cnt_load_val = len_load;
                end
            end
            GATE: begin
                if (retrig) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = len_load;
                end else if (cnt_zero) begin
                    if (GAP_CYCLES > 0) begin
                        state_d      = GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        gate_d = (state_d == GATE);
        busy_d = (state_d != IDLE);
        done_d = (state_q == GATE) && (state_d != GATE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign gate = gate_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_gate_stretch.sv
// Randomised and directed bench for gate_stretch; two instances (gap 2 and gap 0) against a window model.
module tb_gate_stretch;

    localparam int W = 8;

`ifdef GATE_STRETCH_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         trig;
    logic [W-1:0] gate_len;
    logic         gate_a, busy_a, done_a;
    logic         gate_b, busy_b, done_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Per-instance model: gate window [st, ge], busy window [st, pe], done at dc.
    int gapc [2] = '{2, 0};
    int st   [2] = '{0, 0};
    int ge   [2] = '{-1, -1};
    int pe   [2] = '{-1, -1};
    int dc   [2] = '{-1, -1};

    always #5 clk = ~clk;

    gate_stretch #(.CNT_W(W), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .trig(trig), .gate_len(gate_len),
        .gate(gate_a), .busy(busy_a), .done(done_a)
    );

    gate_stretch #(.CNT_W(W), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .trig(trig), .gate_len(gate_len),
        .gate(gate_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Applies the inputs sampled on the edge that ends cycle n.
    task automatic model_edge(input int n);
        int len;
        len = (gate_len == '0) ? 1 : int'(gate_len);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                if (ge[i] > n) ge[i] = n;
                if (pe[i] > n) pe[i] = n;
                dc[i] = -1;
            end else if (trig) begin
                if (n > pe[i]) begin
                    st[i] = n + 1;
                    ge[i] = n + len;
                    pe[i] = ge[i] + gapc[i];
                    dc[i] = ge[i] + 1;
                end else if (RETRIG && n >= st[i] && n <= ge[i]) begin
                    ge[i] = n + len;
                    pe[i] = ge[i] + gapc[i];
                    dc[i] = ge[i] + 1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic eg, eb, ed;
        eg = (st[0] <= cyc) && (cyc <= ge[0]);
        eb = (st[0] <= cyc) && (cyc <= pe[0]);
        ed = (cyc == dc[0]);
        chk("a.gate", 32'(gate_a), 32'(eg));
        chk("a.busy", 32'(busy_a), 32'(eb));
        chk("a.done", 32'(done_a), 32'(ed));
        eg = (st[1] <= cyc) && (cyc <= ge[1]);
        eb = (st[1] <= cyc) && (cyc <= pe[1]);
        ed = (cyc == dc[1]);
        chk("b.gate", 32'(gate_b), 32'(eg));
        chk("b.busy", 32'(busy_b), 32'(eb));
        chk("b.done", 32'(done_b), 32'(ed));
    endtask

    task automatic step(input logic r, input logic t, input logic [W-1:0] l);
        rst_n    = r;
        trig     = t;
        gate_len = l;
        @(posedge clk);
        model_edge(cyc);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst_n    = 1'b0;
        trig     = 1'b0;
        gate_len = '0;

        // Reset then quiet idle
        repeat (3) step(1'b0, 1'b0, 8'd0);
        repeat (20) step(1'b1, 1'b0, 8'd0);

        // Basic 5-cycle gate
        step(1'b1, 1'b1, 8'd5);
        repeat (12) step(1'b1, 1'b0, 8'd5);

        // Zero length, trigger during gap, trigger right after gap
        step(1'b1, 1'b1, 8'd0);
        step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 8'd0);
        step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 8'd0);
        repeat (6) step(1'b1, 1'b0, 8'd0);

        // Reset in the middle of a long gate, then a normal gate
        step(1'b1, 1'b1, 8'd100);
        repeat (19) step(1'b1, 1'b0, 8'd100);
        repeat (2) step(1'b0, 1'b0, 8'd0);
        repeat (3) step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 8'd3);
        repeat (8) step(1'b1, 1'b0, 8'd3);

        // Retrigger four cycles into an 8-cycle gate
        step(1'b1, 1'b1, 8'd8);
        repeat (3) step(1'b1, 1'b0, 8'd8);
        step(1'b1, 1'b1, 8'd8);
        repeat (15) step(1'b1, 1'b0, 8'd8);

        // Retrigger exactly on the last gate cycle
        step(1'b1, 1'b1, 8'd3);
        repeat (2) step(1'b1, 1'b0, 8'd7);
        step(1'b1, 1'b1, 8'd4);
        repeat (10) step(1'b1, 1'b0, 8'd9);

        // Maximum length with length input changing while busy
        step(1'b1, 1'b1, 8'd255);
        for (int i = 0; i < 262; i++) step(1'b1, 1'b0, W'($urandom_range(0, 255)));

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0),
                 W'($urandom_range(0, 12)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
